mem_stage_sram_ctrl: RTL and testbench
======================================

# mem_stage_sram_ctrl

Sequences every MEM-stage data-memory access of the 5-stage MIPS pipeline onto an external 16-bit asynchronous SRAM with programmable wait states. It splits each 32-bit load or store into two half-word SRAM phases. While an access is in flight it drives `ready` low; the pipeline turns this into `freeze` for all stage registers, including the EXE/MEM register. It sits between the EXE/MEM register outputs and the MEM/WB register input.

## Interface
- `WAIT_CYCLES`, 3: SRAM cycles per half-word phase. Legal range 1..15.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low (asserted when 0).
- `MEM_R_EN` input 1: load request from the EXE/MEM register.
- `MEM_W_EN` input 1: store request from the EXE/MEM register.
- `addr` input 32: byte address (ALU_result).
- `wdata` input 32: store value (ST_val).
- `rdata` output 32: load result, valid while `ready`=1 after a read.
- `ready` output 1: 0 means stall the pipeline (freeze = ~ready).
- `addr_err` output 1: sticky misaligned or out-of-range flag (see Configuration).
- `sram_addr` output 18: SRAM half-word address.
- `sram_wdata` output 16: SRAM write data.
- `sram_dq_oe` output 1: 1 means the DQ pad drives `sram_wdata`.
- `sram_rdata` input 16: SRAM read data from the DQ pad.
- `sram_we_n` output 1: SRAM write strobe, active-low.
- `sram_oe_n` output 1: SRAM output enable, active-low.

## Operation
- **States:** IDLE, LO, HI, DONE. Each phase has a wait counter `cnt` that runs 0..WAIT_CYCLES-1.
- **Request:** `req` = MEM_R_EN | MEM_W_EN. If both are set, the access is a write and the read is ignored.
- **IDLE:**
  - With `req`=1, latch the operation, `word` = (addr − BASE_ADDR) >> 2 (bits [16:0]) and `wdata`, then go to LO.
  - Otherwise stay in IDLE.
- **LO:**
  - `sram_addr` = {word, 1'b0}.
  - Write: `sram_wdata` = wdata_q[15:0], `sram_we_n`=0, `sram_dq_oe`=1.
  - Read: `sram_oe_n`=0, and `sram_rdata` is captured into rdata[15:0] when `cnt`=WAIT_CYCLES-1.
  - At `cnt`=WAIT_CYCLES-1, clear `cnt` and go to HI.
- **HI:** same as LO, but uses {word, 1'b1} and bits [31:16], then goes to DONE.
- **DONE:** one cycle, then IDLE.
- **SRAM control outputs:** Moore-decoded from registered state. In IDLE and DONE: `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, and `sram_addr`/`sram_wdata` hold their last value.
- **ready:** combinational = (IDLE & ~req) | DONE. It deasserts in the same cycle a request appears, so the pipeline cannot advance past an unserviced access.
- **rdata:** updates only during read phases; writes leave it unchanged.
- **Address arithmetic:** the subtraction is modulo 2^32. Only bits [18:2] of the difference are used.
- **Reset (any state, including mid-access):**
  - State goes to IDLE and `cnt` to 0.
  - `rdata`, `sram_addr`, `sram_wdata` clear to 0.
  - `sram_we_n`, `sram_oe_n` go to 1; `sram_dq_oe` and `addr_err` go to 0.
  - An interrupted write leaves SRAM contents undefined at that word; no retry is made.

## Timing
- A request first seen in cycle T gives `ready`=0 for cycles T..T+2·WAIT_CYCLES, and `ready`=1 in cycle T+2·WAIT_CYCLES+1 (DONE).
- The number of stall cycles is 2·WAIT_CYCLES+1.
- The next request is sampled in the IDLE cycle after DONE, so back-to-back accesses add no extra bubble.
- With no request, `ready` stays 1 continuously; non-memory instructions see zero latency.
- `rdata` is stable from DONE until the next read's LO capture.

## Configuration
- **With `MEM_ADDR_CHECK_EN` defined:**
  - In IDLE, a request with addr[1:0]≠0 or addr<BASE_ADDR skips LO/HI and goes directly to DONE, one stall cycle total.
  - No SRAM strobe is driven for it, and `addr_err` sets and stays set until reset.
- **Without `MEM_ADDR_CHECK_EN`:**
  - addr[1:0] is ignored and no range check is made.
  - `addr_err` is tied to 0.

## Test plan
All scenarios use WAIT_CYCLES=3 and BASE_ADDR=1024.
- **Store:** W_EN with addr=1028 and wdata=0xDEADBEEF.
  - `sram_addr`=2 with `sram_wdata`=0xBEEF and `sram_we_n`=0 for 3 cycles.
  - Then `sram_addr`=3 with `sram_wdata`=0xDEAD for 3 cycles.
  - `ready`=0 for exactly 7 cycles, then 1.
- **Load after store:** R_EN with addr=1028, with the SRAM model holding the previous store.
  - `rdata`=0xDEADBEEF while `ready`=1 in DONE.
  - `sram_oe_n`=0 only during the 6 phase cycles.
- **Back-to-back:** store to 1032 immediately followed by a load from 1032.
  - Two 7-cycle stalls separated by exactly one `ready`=1 cycle.
  - Load returns the stored value.
- **Both enables:** R_EN=W_EN=1.
  - A write is performed and `rdata` is unchanged.
- **Reset mid-access:** `rst`=0 during HI of a write.
  - Immediately `sram_we_n`=1, `sram_dq_oe`=0 and `rdata`=0.
  - After release, `ready`=1 with no request.
- **Address check (`MEM_ADDR_CHECK_EN`):** load from addr=1030.
  - `ready`=0 for one cycle and no SRAM strobe.
  - `addr_err`=1 and stays 1 through later valid accesses.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_if.sv
// MEM-stage data-memory request/response bundle.
// master = EXE/MEM side, slave = SRAM sequencer.
interface mem_stage_sram_ctrl_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        addr_err;

  modport master (
    output MEM_R_EN, MEM_W_EN, addr, wdata,
    input  rdata, ready, addr_err
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, addr, wdata,
    output rdata, ready, addr_err
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage sequencer: 32-bit access as two 16-bit SRAM phases.
// Optional MEM_ADDR_CHECK_EN traps misaligned/low addresses.
module mem_stage_sram_ctrl #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_sram_ctrl_if.slave bus,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_rdata,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic        req;
  logic        bad;
  logic        start;
  logic        last;
  logic        in_phase;
  logic [16:0] word;
  logic [16:0] word_q;
  logic [15:0] wdata_hi;
  logic        op_wr;
  logic [31:0] rdata_q;

  assign req   = bus.MEM_R_EN | bus.MEM_W_EN;
  assign word  = 17'((bus.addr - BASE_ADDR) >> 2);
  assign start = (state == IDLE) & req & ~bad;
  assign last  = (cnt == LAST);

`ifdef MEM_ADDR_CHECK_EN
  logic err_q;

  assign bad = req &
    ((bus.addr[1:0] != 2'b00) | (bus.addr < BASE_ADDR));

  // Sticky trap flag; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_q <= 1'b0;
    else if (state == IDLE && bad)
      err_q <= 1'b1;
  end

  assign bus.addr_err = err_q;
`else
  assign bad          = 1'b0;
  assign bus.addr_err = 1'b0;
`endif

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state, wait counting and Moore SRAM strobes.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    in_phase   = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_dq_oe = 1'b0;
    bus.ready  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.ready = ~req;
        if (req)
          state_nx = bad ? DONE : LO;
      end
      LO, HI: begin
        in_phase = 1'b1;
        if (last) begin
          cnt_nx   = 4'd0;
          state_nx = (state == LO) ? HI : DONE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE: begin
        bus.ready = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (in_phase) begin
      sram_we_n  = ~op_wr;
      sram_oe_n  = op_wr;
      sram_dq_oe = op_wr;
    end
  end

  // Latch the access and step SRAM address/data per phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr      <= 1'b0;
      word_q     <= 17'd0;
      wdata_hi   <= 16'd0;
      sram_addr  <= 18'd0;
      sram_wdata <= 16'd0;
    end else if (start) begin
      op_wr     <= bus.MEM_W_EN;
      word_q    <= word;
      wdata_hi  <= bus.wdata[31:16];
      sram_addr <= {word, 1'b0};
      if (bus.MEM_W_EN)
        sram_wdata <= bus.wdata[15:0];
    end else if (state == LO && last) begin
      sram_addr <= {word_q, 1'b1};
      if (op_wr)
        sram_wdata <= wdata_hi;
    end
  end

  // Capture read halves on the final wait cycle of each phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rdata_q <= 32'd0;
    else if (last && !op_wr) begin
      if (state == LO)
        rdata_q[15:0] <= sram_rdata;
      else if (state == HI)
        rdata_q[31:16] <= sram_rdata;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl.
// Driver queues expectations; monitor checks each completion.
module tb_mem_stage_sram_ctrl;

  localparam int W = 3;

  typedef struct {
    int          stall;
    int          we_lo;
    int          we_hi;
    int          oe_lo;
    int          oe_hi;
    logic [17:0] lo_a;
    logic [15:0] lo_d;
    logic [15:0] hi_d;
    logic [31:0] rdata;
    logic        err;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  int total = 0;
  int bad   = 0;

  exp_t q[$];
  exp_t em;
  bit   mon_en = 1'b0;
  bit   busy   = 1'b0;
  int   stall, wlo, whi, olo, ohi, hrun, gap;

  logic [15:0] mem [0:255];

  mem_stage_sram_ctrl_if bus();

  mem_stage_sram_ctrl #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (32'd1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_dq_oe(sram_dq_oe),
    .sram_rdata(sram_rdata),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!sram_we_n)
      mem[sram_addr[7:0]] <= sram_wdata;

  assign sram_rdata = sram_oe_n ? 16'h0000 : mem[sram_addr[7:0]];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(
    input int st, input int wl, input int wh,
    input int ol, input int oh,
    input logic [17:0] la, input logic [15:0] ld,
    input logic [15:0] hd, input logic [31:0] rd,
    input logic er, input int gp);
    exp_t e;
    e.stall = st;  e.we_lo = wl; e.we_hi = wh;
    e.oe_lo = ol;  e.oe_hi = oh; e.lo_a = la;
    e.lo_d  = ld;  e.hi_d  = hd; e.rdata = rd;
    e.err   = er;  e.gap   = gp;
    return e;
  endfunction

  // Monitor: tally each stall window, compare at the ready rise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!bus.ready) begin
        if (!busy) begin
          busy = 1'b1;
          gap  = hrun;
          stall = 0; wlo = 0; whi = 0; olo = 0; ohi = 0;
        end
        stall++;
        if (q.size() != 0) begin
          em = q[0];
          if (!sram_we_n && sram_dq_oe && sram_oe_n) begin
            if (sram_addr == em.lo_a && sram_wdata == em.lo_d)
              wlo++;
            if (sram_addr == em.lo_a + 18'd1 &&
                sram_wdata == em.hi_d)
              whi++;
          end
          if (!sram_oe_n && sram_we_n && !sram_dq_oe) begin
            if (sram_addr == em.lo_a)
              olo++;
            if (sram_addr == em.lo_a + 18'd1)
              ohi++;
          end
        end
      end else if (busy) begin
        busy = 1'b0;
        hrun = 1;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got 1 want 0");
        end else begin
          em = q.pop_front();
          chk("stall", stall, em.stall);
          chk("we_lo", wlo, em.we_lo);
          chk("we_hi", whi, em.we_hi);
          chk("oe_lo", olo, em.oe_lo);
          chk("oe_hi", ohi, em.oe_hi);
          chk("rdata", bus.rdata, em.rdata);
          chk("addr_err", {31'd0, bus.addr_err}, {31'd0, em.err});
          if (em.gap >= 0)
            chk("gap", gap, em.gap);
        end
      end else begin
        hrun++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic r, input logic w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input exp_t e);
    int n;
    q.push_back(e);
    bus.MEM_R_EN = r;
    bus.MEM_W_EN = w;
    bus.addr     = a;
    bus.wdata    = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.ready && n < 60);
    chk("done_in_time", {31'd0, bus.ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
  endtask

  initial begin
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    bus.addr     = 32'd0;
    bus.wdata    = 32'd0;
    rst = 1'b0;
    idle(2);

    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_addr_err", {31'd0, bus.addr_err}, 32'd0);

    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, bus.ready}, 32'd1);
    end
    @(posedge clk);
    #1;
    hrun   = 0;
    mon_en = 1'b1;

    issue(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF,
          mk(7, 3, 3, 0, 0, 18'd2, 16'hBEEF, 16'hDEAD,
             32'h0, 1'b0, -1));
    idle(2);
    issue(1'b1, 1'b0, 32'd1028, 32'h0,
          mk(7, 0, 0, 3, 3, 18'd2, 16'h0, 16'h0,
             32'hDEADBEEF, 1'b0, -1));
    idle(2);
    issue(1'b0, 1'b1, 32'd1032, 32'h12345678,
          mk(7, 3, 3, 0, 0, 18'd4, 16'h5678, 16'h1234,
             32'hDEADBEEF, 1'b0, -1));
    issue(1'b1, 1'b0, 32'd1032, 32'h0,
          mk(7, 0, 0, 3, 3, 18'd4, 16'h0, 16'h0,
             32'h12345678, 1'b0, 1));
    idle(2);
    issue(1'b1, 1'b1, 32'd1036, 32'hCAFEF00D,
          mk(7, 3, 3, 0, 0, 18'd6, 16'hF00D, 16'hCAFE,
             32'h12345678, 1'b0, -1));
    idle(1);
    issue(1'b1, 1'b0, 32'd1036, 32'h0,
          mk(7, 0, 0, 3, 3, 18'd6, 16'h0, 16'h0,
             32'hCAFEF00D, 1'b0, -1));
    idle(1);
`ifdef MEM_ADDR_CHECK_EN
    issue(1'b1, 1'b0, 32'd1030, 32'h0,
          mk(1, 0, 0, 0, 0, 18'd2, 16'h0, 16'h0,
             32'hCAFEF00D, 1'b1, -1));
    idle(1);
    issue(1'b0, 1'b1, 32'd4, 32'h11112222,
          mk(1, 0, 0, 0, 0, 18'd0, 16'h2222, 16'h1111,
             32'hCAFEF00D, 1'b1, -1));
    idle(1);
    issue(1'b1, 1'b0, 32'd1028, 32'h0,
          mk(7, 0, 0, 3, 3, 18'd2, 16'h0, 16'h0,
             32'hDEADBEEF, 1'b1, -1));
`else
    issue(1'b1, 1'b0, 32'd1030, 32'h0,
          mk(7, 0, 0, 3, 3, 18'd2, 16'h0, 16'h0,
             32'hDEADBEEF, 1'b0, -1));
`endif
    idle(2);
    chk("queue_empty", q.size(), 32'd0);

    mon_en = 1'b0;
    bus.MEM_W_EN = 1'b1;
    bus.addr     = 32'd1040;
    bus.wdata    = 32'h55AA33CC;
    idle(4);
    chk("hi_we_n", {31'd0, sram_we_n}, 32'd0);
    chk("hi_addr", {14'd0, sram_addr}, 32'd9);
    chk("hi_wdata", {16'd0, sram_wdata}, 32'h55AA);
    rst = 1'b0;
    #1;
    chk("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("midrst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("midrst_rdata", bus.rdata, 32'd0);
    chk("midrst_addr", {14'd0, sram_addr}, 32'd0);
    bus.MEM_W_EN = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", {31'd0, bus.ready}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
